// File: rtl/player_anim_ctrl.sv
// Per-frame action sequencer for one player sprite: idle / windup / throw / hit.
// Optional hit shake on y_off is enabled by defining PLAYER_HIT_SHAKE_EN.
module player_anim_ctrl #(
  parameter int unsigned WINDUP_FRAMES = 20,
  parameter int unsigned THROW_FRAMES  = 10,
  parameter int unsigned HIT_FRAMES    = 30,
  parameter int unsigned SPRITE_WORDS  = 24780
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        throw_req,
  input  logic        hit,
  output logic [1:0]  frame_sel,
  output logic [16:0] rom_base,
  output logic [2:0]  y_off,
  output logic        busy,
  output logic        throw_fire
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WINDUP = 2'd1,
    S_THROW  = 2'd2,
    S_HIT    = 2'd3
  } state_t;

  localparam logic [7:0]  WINDUP_LAST = 8'(WINDUP_FRAMES - 1);
  localparam logic [7:0]  THROW_LAST  = 8'(THROW_FRAMES - 1);
  localparam logic [7:0]  HIT_LAST    = 8'(HIT_FRAMES - 1);
  localparam logic [16:0] BASE_WINDUP = 17'(SPRITE_WORDS);
  localparam logic [16:0] BASE_THROW  = 17'(2 * SPRITE_WORDS);
  localparam logic [16:0] BASE_HIT    = 17'(3 * SPRITE_WORDS);

  state_t      state, state_nxt;
  logic [7:0]  frame_cnt, cnt_nxt;
  logic        vsync_q, vsync_arm, hit_pend;
  logic        tick, fire_nxt;
  logic [16:0] base_nxt;

  // vsync_arm blocks a false edge when vsync is already high as reset releases.
  assign tick = vsync & ~vsync_q & vsync_arm;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q   <= 1'b0;
      vsync_arm <= 1'b0;
      hit_pend  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (!vsync)
        vsync_arm <= 1'b1;
      if (tick)
        hit_pend <= 1'b0;
      else if (hit)
        hit_pend <= 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = frame_cnt;
    fire_nxt  = 1'b0;
    if (tick) begin
      if (hit_pend || hit) begin
        state_nxt = S_HIT;
        cnt_nxt   = 8'd0;
      end else begin
        cnt_nxt = frame_cnt + 8'd1;
        unique case (state)
          S_IDLE: begin
            if (throw_req) begin
              state_nxt = S_WINDUP;
              cnt_nxt   = 8'd0;
            end
          end
          S_WINDUP: begin
            if (frame_cnt == WINDUP_LAST) begin
              state_nxt = S_THROW;
              cnt_nxt   = 8'd0;
              fire_nxt  = 1'b1;
            end
          end
          S_THROW: begin
            if (frame_cnt == THROW_LAST) begin
              state_nxt = S_IDLE;
              cnt_nxt   = 8'd0;
            end
          end
          S_HIT: begin
            if (frame_cnt == HIT_LAST) begin
              state_nxt = S_IDLE;
              cnt_nxt   = 8'd0;
            end
          end
          default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = 8'd0;
          end
        endcase
      end
    end
  end

  always_comb begin
    base_nxt = 17'd0;
    unique case (state_nxt)
      S_WINDUP: base_nxt = BASE_WINDUP;
      S_THROW:  base_nxt = BASE_THROW;
      S_HIT:    base_nxt = BASE_HIT;
      default:  base_nxt = 17'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      frame_cnt  <= 8'd0;
      frame_sel  <= 2'd0;
      rom_base   <= 17'd0;
      busy       <= 1'b0;
      throw_fire <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_cnt  <= cnt_nxt;
      frame_sel  <= state_nxt;
      rom_base   <= base_nxt;
      busy       <= (state_nxt != S_IDLE);
      throw_fire <= fire_nxt;
    end
  end

`ifdef PLAYER_HIT_SHAKE_EN
  // Shake toggles every four frames of the hit count.
  always_ff @(posedge clk) begin
    if (rst)
      y_off <= 3'd0;
    else
      y_off <= (state_nxt == S_HIT && cnt_nxt[2]) ? 3'd4 : 3'd0;
  end
`else
  assign y_off = 3'd0;
`endif

endmodule
